// File: rtl/t03_icache_lookup.sv
// Direct-mapped one-word-per-line read cache with write-update and miss fill; T03_ICACHE_STATS_EN adds hit/miss counters.
// Hits resolve in the lookup cycle; a miss stalls the requester until the fill ack is absorbed (min 2 cycles).
module t03_icache_lookup #(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_req,
    input  logic [31:0] addr_in,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        flush,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        hit,
    output logic [31:0] cache_out,
    output logic        stall
`ifdef T03_ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [TAG_W-1:0]       tag_d  [NUM_LINES];
    logic [31:0]            data_q [NUM_LINES];
    logic [31:0]            data_d [NUM_LINES];
    logic                   drop_q, drop_d;
    logic [31:0]            mem_addr_q, mem_addr_d;

    logic [IDX_W-1:0]       rd_idx, wr_idx, fill_idx;
    logic [TAG_W-1:0]       rd_tag, wr_tag, fill_tag;
    logic                   lookup_hit, miss_start, fill_done, fill_wr;
    logic                   wr_match, store_hits_fill;
    logic                   unused_addr_bits;

    assign rd_idx   = addr_in[IDX_W+1:2];
    assign rd_tag   = addr_in[31:IDX_W+2];
    assign wr_idx   = wr_addr[IDX_W+1:2];
    assign wr_tag   = wr_addr[31:IDX_W+2];
    assign fill_idx = mem_addr_q[IDX_W+1:2];
    assign fill_tag = mem_addr_q[31:IDX_W+2];
    assign unused_addr_bits = ^{addr_in[1:0], wr_addr[1:0]};

    assign lookup_hit = read_req & valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag) & (state_q == IDLE);
    assign miss_start = (state_q == IDLE) & read_req & ~lookup_hit & ~flush;
    assign fill_done  = (state_q == FILL) & mem_ack;
    assign fill_wr    = fill_done & ~drop_q;
    assign wr_match   = wr_en & valid_q[wr_idx] & (tag_q[wr_idx] == wr_tag);
    // A store to the word being filled is newer than the memory copy.
    assign store_hits_fill = wr_en & (wr_addr[31:2] == mem_addr_q[31:2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_start) state_d = FILL;
            FILL:    if (mem_ack)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = (state_q == FILL);
        hit       = lookup_hit;
        cache_out = read_req ? data_q[rd_idx] : 32'h0;
        stall     = (state_q == FILL) | (read_req & ~lookup_hit);
    end

    assign mem_addr = mem_addr_q;

    always_comb begin
        mem_addr_d = miss_start ? {addr_in[31:2], 2'b00} : mem_addr_q;
        drop_d     = drop_q;
        if (fill_done) begin
            drop_d = 1'b0;
        end else if ((state_q == FILL) && flush) begin
            drop_d = 1'b1;
        end
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        // Fill is applied after write-update so it replaces a conflicting line; flush overrides both.
        for (int i = 0; i < NUM_LINES; i++) begin
            if (wr_match && (wr_idx == IDX_W'(i))) begin
                data_d[i] = wr_data;
            end
            if (fill_wr && (fill_idx == IDX_W'(i))) begin
                valid_d[i] = 1'b1;
                tag_d[i]   = fill_tag;
                data_d[i]  = store_hits_fill ? wr_data : mem_data;
            end
            if (flush) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            drop_q     <= 1'b0;
            mem_addr_q <= 32'h0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= 32'h0;
            end
        end else begin
            valid_q    <= valid_d;
            drop_q     <= drop_d;
            mem_addr_q <= mem_addr_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
        end
    end

`ifdef T03_ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q + 32'(lookup_hit);
        miss_count_d = miss_count_q + 32'(miss_start);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= 32'h0;
            miss_count_q <= 32'h0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_t03_icache_lookup.sv
// Directed plus randomized bench for t03_icache_lookup against a word-address reference model.
module tb_t03_icache_lookup;

    localparam int NL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_req, wr_en, flush, mem_ack;
    logic [31:0] addr_in, wr_addr, wr_data, mem_data;
    logic        mem_req, hit, stall;
    logic [31:0] mem_addr, cache_out;
`ifdef T03_ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    t03_icache_lookup #(.NUM_LINES(NL)) dut (
        .clk(clk), .rst(rst), .read_req(read_req), .addr_in(addr_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush),
        .mem_ack(mem_ack), .mem_data(mem_data), .mem_req(mem_req),
        .mem_addr(mem_addr), .hit(hit), .cache_out(cache_out), .stall(stall)
`ifdef T03_ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each line remembers the full word address it holds.
    bit          m_vld [NL];
    logic [29:0] m_wa  [NL];
    logic [31:0] m_dat [NL];
    bit          m_fill, m_drop;
    logic [31:0] m_maddr, m_hits, m_misses;

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % NL);
    endfunction

    function automatic bit exp_hit();
        int l = line_of(addr_in);
        return read_req && !m_fill && m_vld[l] && (m_wa[l] == addr_in[31:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_vld[i] = 0; m_wa[i] = '0; m_dat[i] = '0;
        end
        m_fill = 0; m_drop = 0; m_maddr = '0; m_hits = '0; m_misses = '0;
    endtask

    task automatic model_update();
        bit h = exp_hit();
        int wl = line_of(wr_addr);
        int fl = line_of(m_maddr);
        if (h) m_hits++;
        if (wr_en && m_vld[wl] && (m_wa[wl] == wr_addr[31:2])) m_dat[wl] = wr_data;
        if (m_fill) begin
            if (mem_ack) begin
                if (!m_drop) begin
                    m_vld[fl] = 1;
                    m_wa[fl]  = m_maddr[31:2];
                    m_dat[fl] = (wr_en && wr_addr[31:2] == m_maddr[31:2]) ? wr_data : mem_data;
                end
                m_fill = 0;
                m_drop = 0;
            end else if (flush) begin
                m_drop = 1;
            end
        end else if (read_req && !h && !flush) begin
            m_fill  = 1;
            m_maddr = {addr_in[31:2], 2'b00};
            m_misses++;
        end
        if (flush) for (int i = 0; i < NL; i++) m_vld[i] = 0;
    endtask

    task automatic check_outputs();
        bit h = exp_hit();
        check_val("hit", 32'(hit), 32'(h));
        check_val("cache_out", cache_out, read_req ? m_dat[line_of(addr_in)] : 32'h0);
        check_val("stall", 32'(stall), 32'(m_fill || (read_req && !h)));
        check_val("mem_req", 32'(mem_req), 32'(m_fill));
        check_val("mem_addr", mem_addr, m_maddr);
`ifdef T03_ICACHE_STATS_EN
        check_val("hit_count", hit_count, m_hits);
        check_val("miss_count", miss_count, m_misses);
`endif
    endtask

    // Inputs are set just after a negedge; outputs are compared 1 time unit later.
    task automatic cycle();
        #1 check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic expect_now(input string t, input bit h, input bit s, input logic [31:0] d, input bit use_d);
        #1;
        check_val({t, "_hit"}, 32'(hit), 32'(h));
        check_val({t, "_stall"}, 32'(stall), 32'(s));
        if (use_d) check_val({t, "_data"}, cache_out, d);
    endtask

    task automatic miss_fill(input logic [31:0] a, input int waits, input logic [31:0] d);
        read_req = 1; addr_in = a;
        cycle();
        for (int i = 0; i < waits; i++) cycle();
        mem_ack = 1; mem_data = d;
        cycle();
        mem_ack = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h1000 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
        return a;
    endfunction

    initial begin
        rst = 1; read_req = 0; addr_in = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        flush = 0; mem_ack = 0; mem_data = '0;
        model_reset();
        #1;
        check_val("rst_mem_req", 32'(mem_req), 32'h0);
        check_val("rst_mem_addr", mem_addr, 32'h0);
        check_val("rst_stall", 32'(stall), 32'h0);
        check_val("rst_hit", 32'(hit), 32'h0);
        check_val("rst_cache_out", cache_out, 32'h0);
        @(negedge clk);
        rst = 0;

        // Cold miss: ack three cycles after mem_req rises.
        read_req = 1; addr_in = 32'h0000_0104;
        cycle();
        #1 check_val("cold_mem_addr", mem_addr, 32'h0000_0104);
        check_val("cold_mem_req", 32'(mem_req), 32'h1);
        for (int i = 0; i < 2; i++) cycle();
        cycle();
        mem_ack = 1; mem_data = 32'hDEAD_BEEF;
        cycle();
        mem_ack = 0;
        expect_now("cold", 1, 0, 32'hDEAD_BEEF, 1);
        cycle();

        // Conflict on index 1 evicts 0x104.
        miss_fill(32'h0000_0124, 1, 32'hC0FF_EE01);
        read_req = 1; addr_in = 32'h0000_0104;
        expect_now("conflict", 0, 1, 32'h0, 0);
        miss_fill(32'h0000_0104, 0, 32'hDEAD_BEEF);

        // Write-update to a resident line, then a non-allocating store.
        read_req = 0; wr_en = 1; wr_addr = 32'h0000_0104; wr_data = 32'h1234_5678;
        cycle();
        wr_en = 0; read_req = 1; addr_in = 32'h0000_0104;
        expect_now("wupd", 1, 0, 32'h1234_5678, 1);
        cycle();
        read_req = 0; wr_en = 1; wr_addr = 32'h0000_0200; wr_data = 32'h0000_0055;
        cycle();
        wr_en = 0; read_req = 1; addr_in = 32'h0000_0200;
        expect_now("noalloc", 0, 1, 32'h0, 0);
        miss_fill(32'h0000_0200, 0, 32'h0000_0077);

        // Flush during fill drops the returned word and the request misses again.
        read_req = 1; addr_in = 32'h0000_0108;
        cycle();
        flush = 1;
        cycle();
        flush = 0; mem_ack = 1; mem_data = 32'hAAAA_5555;
        cycle();
        mem_ack = 0;
        expect_now("flushfill", 0, 1, 32'h0, 0);
        cycle();
        #1 check_val("flushfill_rereq", 32'(mem_req), 32'h1);
        mem_ack = 1; mem_data = 32'hAAAA_5555;
        cycle();
        mem_ack = 0;

        // Store to the word being filled wins over the memory data.
        read_req = 1; addr_in = 32'h0000_010C;
        cycle();
        mem_ack = 1; mem_data = 32'h1111_1111;
        wr_en = 1; wr_addr = 32'h0000_010C; wr_data = 32'h2222_2222;
        cycle();
        mem_ack = 0; wr_en = 0;
        expect_now("storewins", 1, 0, 32'h2222_2222, 1);
        cycle();

        // Reset mid-fill: outputs collapse immediately and the ack is lost.
        read_req = 1; addr_in = 32'h0000_0140;
        cycle();
        cycle();
        rst = 1; read_req = 0; mem_ack = 1; mem_data = 32'hBAD0_BAD0;
        #1;
        check_val("rstfill_mem_req", 32'(mem_req), 32'h0);
        check_val("rstfill_stall", 32'(stall), 32'h0);
        check_val("rstfill_hit", 32'(hit), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0; mem_ack = 0;
        read_req = 1; addr_in = 32'h0000_0140;
        expect_now("rstfill_lost", 0, 1, 32'h0, 0);
        miss_fill(32'h0000_0140, 0, 32'h0000_0140);
        cycle();
        cycle();
        read_req = 0;
`ifdef T03_ICACHE_STATS_EN
        #1;
        check_val("stats_miss", miss_count, 32'd1);
        check_val("stats_hit", hit_count, 32'd2);
`endif

        // Randomized traffic; the requester holds its request while a fill is pending.
        for (int n = 0; n < 3000; n++) begin
            if (!m_fill) begin
                read_req = ($urandom_range(0, 3) != 0);
                addr_in  = rand_addr();
            end
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = (m_fill && $urandom_range(0, 2) == 0) ? m_maddr : rand_addr();
            wr_data  = $urandom;
            flush    = ($urandom_range(0, 24) == 0);
            mem_ack  = m_fill ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mem_data = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/t03_icache_lookup.md
# t03_icache_lookup

Direct-mapped, single-word-per-line read cache sitting between the fetch/load address path and the memory handler, directly upstream of the cache routing stage. It performs a combinational tag lookup, drives `hit` and `cache_out` to the routing stage, and on a miss runs a fill sequence against the memory handler. Writes from the datapath update any matching resident line (write-update), so the routing stage never sees stale data.

## Interface

**Parameters**
- `NUM_LINES`, default 8: number of lines; must be a power of two, ≥2.
- `IDX_W`, default `$clog2(NUM_LINES)`: index width (derived; do not override).

**Ports**
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `read_req` input 1: lookup request for `addr_in`.
- `addr_in` input 32: byte address. Index is `addr_in[IDX_W+1:2]`; tag is `addr_in[31:IDX_W+2]`; `[1:0]` ignored.
- `wr_en` input 1: datapath store in progress.
- `wr_addr` input 32: store byte address, decoded like `addr_in`.
- `wr_data` input 32: store data.
- `flush` input 1: invalidate all lines.
- `mem_ack` input 1: memory handler has valid `mem_data` this cycle.
- `mem_data` input 32: read data from memory handler.
- `mem_req` output 1: fill request to memory handler.
- `mem_addr` output 32: registered fill address, word aligned (`[1:0]`=0).
- `hit` output 1: lookup hit (combinational).
- `cache_out` output 32: data of the indexed line (combinational).
- `stall` output 1: requester must hold `read_req`/`addr_in`.

## Operation

- Storage: per line `valid`, tag (`32-IDX_W-2` bits), and 32-bit data, all flops.
- `hit = read_req & valid[idx] & (tag[idx]==addr_tag) & (state==IDLE)`.
- `cache_out` = `data[idx]` whenever `read_req` is high, else 0.
- FSM states:
  - **IDLE**: if `read_req & !hit & !flush`, latch `{addr_in[31:2],2'b00}` into `mem_addr`, latch index/tag, go to **FILL**.
  - **FILL**: `mem_req`=1. On `mem_ack`, write `mem_data`, tag, `valid`=1 into the latched line (unless `drop` is set), clear `drop`, go to **IDLE**.
- `stall = (state==FILL) | (read_req & !hit)`.
- Write-update: on `wr_en`, if the `wr_addr` line is valid and its tag matches, replace its data with `wr_data`. Writes never allocate.
- `flush`: clears every `valid` at the edge. In IDLE it suppresses miss entry that cycle. In FILL the fill continues, but the `drop` flag is set and the returned word is discarded.
- Simultaneous fill-ack and `wr_en` to the same word: line is written with `wr_data` and marked valid (store wins). Different lines: both updates occur.
- Simultaneous `flush` and fill-ack: line stays invalid.

## Timing

- Reset values: all `valid`=0, `drop`=0, state=IDLE, `mem_req`=0, `mem_addr`=0, `stall`=0, `hit`=0, `cache_out`=0 (no `read_req`).
- Hit latency: 0 cycles (same cycle as `read_req`).
- Miss:
  - Cycle 0: `stall`=1.
  - Cycle 1 onward: `mem_req`=1 with stable `mem_addr` until the `mem_ack` cycle k.
  - Cycle k+1: IDLE; a held request hits.
- Minimum miss penalty is 2 cycles (ack in cycle 1).
- `mem_req` drops in the cycle after the ack edge. `mem_ack` outside FILL is ignored.
- Reset asserted mid-fill: state, `valid`, and `drop` clear immediately. The ack is lost and no line is written.

## Configuration

- `T03_ICACHE_STATS_EN` defined: adds outputs `hit_count` [31:0] and `miss_count` [31:0]. Both reset to 0 and wrap at 2^32.
  - `hit_count` +1 per cycle with `hit`=1.
  - `miss_count` +1 per IDLE→FILL transition.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan

- **Cold miss:** Reset, then `read_req`=1, `addr_in`=0x0000_0104, `mem_ack` 3 cycles after `mem_req` rises with `mem_data`=0xDEAD_BEEF.
  - Required: `mem_addr`=0x0000_0104.
  - Next cycle after ack: `hit`=1, `cache_out`=0xDEAD_BEEF, `stall`=0.
- **Conflict:** With 0x104 resident, read 0x0000_0124 (same index, NUM_LINES=8).
  - Required: miss, fill replaces the line; a subsequent read of 0x104 misses again.
- **Write-update:** 0x104 resident, `wr_en` with `wr_addr`=0x104, `wr_data`=0x1234_5678.
  - Required: next read hits with 0x1234_5678. A write to non-resident 0x200 causes no allocation (read 0x200 misses).
- **Flush during fill:** Assert `flush` during FILL, then ack with 0xAAAA_5555.
  - Required: the line stays invalid and the held request misses again, issuing a new `mem_req`.
- **Reset mid-fill and stats:** Assert `rst` while `mem_req`=1.
  - Required: `mem_req`, `stall`, and `hit` go to 0 immediately.
  - With `T03_ICACHE_STATS_EN`, after 1 miss and 2 hit cycles: `miss_count`=1, `hit_count`=2.
